mole_hit_scorer: RTL and testbench

- Responder side of the mole display path: the FSM's `new_mole` pulse and the random mole position light one LEDR. This block watches SW for the player's "whack".
- Reports hit / miss / wrong-switch as one-cycle pulses back to the FSM.
- Measures reaction time in ms and maintains the running score for the 7-segment display.
- Sits between the switch inputs, the mole generator and the game FSM.

---
 rtl/mole_hit_scorer.sv | 225 ++++++++++++++++++++++
 tb/tb_mole_hit_scorer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_hit_scorer.sv
// -----------------------------------------------------------------------------
// mole_hit_scorer
//
// Responder side of the whack-a-mole display path. When the game FSM pulses
// new_mole, the block latches the mole position and the hit window, then
// watches the player switches for a "whack". A toggle on any switch counts.
// Either edge of that switch is accepted.
//
// Every ARMED cycle is resolved to exactly one outcome, or to none. The
// outcomes in priority order are:
//   1. replaced  - another mole arrives          -> miss, re-arm
//   2. hit       - the mole's switch toggled     -> hit, score up, idle
//   3. timeout   - the ms counter reached window -> miss, idle
//   4. wrong     - any other switch toggled      -> wrong, score down
//
// The hit, miss and wrong pulses are registered, so each one lasts exactly
// one clock. reaction_ms holds the ms count of the most recent hit. score
// saturates at SCORE_MAX and never drops below zero.
//
// Ports
//   clk            system clock (CLOCK_50)
//   reset          synchronous, active-high reset
//   new_mole       1-cycle pulse: a mole appears at mole_position
//   mole_position  index of the lit mole, sampled on new_mole
//   window_ms      hit window in ms, sampled on new_mole
//   sw             raw asynchronous switch levels
//   armed          high while a mole is waiting to be hit
//   hit            1-cycle pulse: correct switch toggled inside the window
//   miss           1-cycle pulse: window expired or mole replaced
//   wrong          1-cycle pulse: non-mole switch toggled while armed
//   reaction_ms    ms elapsed at the last hit, held until the next hit
//   score          binary score, 0..SCORE_MAX
// -----------------------------------------------------------------------------
module mole_hit_scorer #(
  parameter int CLKS_PER_MS = 50000,
  parameter int NUM_SW      = 18,
  parameter int SCORE_MAX   = 9999
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              new_mole,
  input  logic [4:0]        mole_position,
  input  logic [11:0]       window_ms,
  input  logic [NUM_SW-1:0] sw,
  output logic              armed,
  output logic              hit,
  output logic              miss,
  output logic              wrong,
  output logic [11:0]       reaction_ms,
  output logic [13:0]       score
);

  // Width of the sub-millisecond counter. The guard keeps the width legal
  // when the bench shrinks the tick down to a single clock.
  localparam int SUB_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(CLKS_PER_MS - 1);
  localparam logic [13:0]      SCORE_TOP = 14'(SCORE_MAX);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ARMED = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Switch input path: a two-flop synchroniser, then a previous-value register
  // for edge detection.
  // ---------------------------------------------------------------------------
  logic [NUM_SW-1:0] sync1_q;
  logic [NUM_SW-1:0] sync2_q;
  logic [NUM_SW-1:0] prev_q;
  logic [NUM_SW-1:0] toggle;

  // NOTE: sequential state is written with non-blocking assignments only.
  // Every flop then samples the pre-edge value, so the synchroniser chain
  // shifts one stage per clock no matter how the statements are ordered.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: all three stages load the live switch levels during reset.
      // When reset releases, sync2 and prev already agree, so a switch
      // left in the "on" position does not appear as a whack.
      sync1_q <= sw;
      sync2_q <= sw;
      prev_q  <= sw;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign toggle = sync2_q ^ prev_q;

  // ---------------------------------------------------------------------------
  // Game state
  // ---------------------------------------------------------------------------
  state_t            state_q,    state_d;
  logic [4:0]        pos_q,      pos_d;
  logic [11:0]       win_q,      win_d;
  logic [SUB_W-1:0]  sub_q,      sub_d;
  logic [11:0]       ms_q,       ms_d;
  logic              hit_q,      hit_d;
  logic              miss_q,     miss_d;
  logic              wrong_q,    wrong_d;
  logic [11:0]       reaction_q, reaction_d;
  logic [13:0]       score_q,    score_d;

  // A mole position outside the switch range gets an empty mask. Such a
  // mole can never be hit, and every toggle against it is a wrong switch.
  logic              pos_ok;
  logic [NUM_SW-1:0] pos_mask;
  logic              hit_sel;
  logic              timeout;
  logic              any_toggle;

  assign pos_ok     = 32'(pos_q) < 32'(NUM_SW);
  assign pos_mask   = pos_ok ? (NUM_SW'(1) << pos_q) : '0;
  assign hit_sel    = |(toggle & pos_mask);
  assign timeout    = (ms_q == win_q);
  assign any_toggle = |toggle;

  always_comb begin
    // NOTE: every signal gets a default before the case statement. No path
    // through this block can leave a signal unassigned, so no latch is
    // inferred. It also means each branch only lists what it changes.
    state_d    = state_q;
    pos_d      = pos_q;
    win_d      = win_q;
    sub_d      = sub_q;
    ms_d       = ms_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    wrong_d    = 1'b0;
    reaction_d = reaction_q;
    score_d    = score_q;

    unique case (state_q)
      S_IDLE: begin
        // Toggles seen in IDLE are dropped. The prev register still
        // absorbs them, so they do not carry over into the next mole.
        if (new_mole) begin
          pos_d   = mole_position;
          win_d   = window_ms;
          sub_d   = '0;
          ms_d    = '0;
          state_d = S_ARMED;
        end
      end

      S_ARMED: begin
        // The ms counter advances on the cycle the sub-ms counter wraps.
        if (sub_q == SUB_LAST) begin
          sub_d = '0;
          ms_d  = ms_q + 12'd1;
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end

        if (new_mole) begin
          // The old mole is replaced: count it as a miss and re-arm.
          miss_d = 1'b1;
          pos_d  = mole_position;
          win_d  = window_ms;
          sub_d  = '0;
          ms_d   = '0;
        end else if (hit_sel) begin
          // The hit is checked ahead of the timeout, so a whack that lands
          // on the expiry cycle still counts. Any wrong toggles in the same
          // cycle are ignored.
          hit_d      = 1'b1;
          reaction_d = ms_q;
          if (score_q != SCORE_TOP) begin
            score_d = score_q + 14'd1;
          end
          state_d = S_IDLE;
        end else if (timeout) begin
          miss_d  = 1'b1;
          state_d = S_IDLE;
        end else if (any_toggle) begin
          // Several wrong switches in one cycle cost a single point.
          wrong_d = 1'b1;
          if (score_q != 14'd0) begin
            score_d = score_q - 14'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pos_q      <= '0;
      win_q      <= '0;
      sub_q      <= '0;
      ms_q       <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      wrong_q    <= 1'b0;
      reaction_q <= '0;
      score_q    <= '0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      win_q      <= win_d;
      sub_q      <= sub_d;
      ms_q       <= ms_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      wrong_q    <= wrong_d;
      reaction_q <= reaction_d;
      score_q    <= score_d;
    end
  end

  assign armed       = (state_q == S_ARMED);
  assign hit         = hit_q;
  assign miss        = miss_q;
  assign wrong       = wrong_q;
  assign reaction_ms = reaction_q;
  assign score       = score_q;

endmodule

// File: tb/tb_mole_hit_scorer.sv
// -----------------------------------------------------------------------------
// tb_mole_hit_scorer
//
// Directed bench for mole_hit_scorer, built with CLKS_PER_MS = 10. Inputs are
// driven 1 time unit after each rising edge. Outputs are sampled at the same
// point, once the registered pulses have settled.
//
// Timing rules behind the expected values below, where edge a is the edge
// that samples new_mole:
//   - After edge a+n, the ms counter holds floor(n/10).
//   - A switch change driven after edge a+n shows up as a pulse after edge
//     a+n+3. The outcome is decided in the cycle after edge a+n+2.
//   - A timeout decision needs ms == window. That first holds in the cycle
//     after edge a+10*window, so the miss pulse appears after edge
//     a+10*window+1.
// -----------------------------------------------------------------------------
module tb_mole_hit_scorer;

  localparam int NUM_SW = 18;

  logic              clk = 1'b0;
  logic              reset;
  logic              new_mole;
  logic [4:0]        mole_position;
  logic [11:0]       window_ms;
  logic [NUM_SW-1:0] sw;
  logic              armed;
  logic              hit;
  logic              miss;
  logic              wrong;
  logic [11:0]       reaction_ms;
  logic [13:0]       score;

  int total = 0;
  int bad   = 0;

  mole_hit_scorer #(
    .CLKS_PER_MS (10),
    .NUM_SW      (NUM_SW),
    .SCORE_MAX   (9999)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .new_mole      (new_mole),
    .mole_position (mole_position),
    .window_ms     (window_ms),
    .sw            (sw),
    .armed         (armed),
    .hit           (hit),
    .miss          (miss),
    .wrong         (wrong),
    .reaction_ms   (reaction_ms),
    .score         (score)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Present a one-cycle new_mole. On return, edge a has just passed.
  task automatic arm(input logic [4:0] p, input logic [11:0] w);
    new_mole      = 1'b1;
    mole_position = p;
    window_ms     = w;
    tick();
    new_mole      = 1'b0;
  endtask

  // Flip the switches in mask, then advance to the edge where the outcome
  // pulse is visible.
  task automatic whack(input logic [NUM_SW-1:0] mask);
    sw = sw ^ mask;
    tick();
    tick();
    tick();
  endtask

  // Watchdog: ends a run that would otherwise hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_miss;
    int miss_count;
    int hit_count;

    reset         = 1'b1;
    new_mole      = 1'b0;
    mole_position = '0;
    window_ms     = '0;
    sw            = '0;
    repeat (3) tick();

    // ---- reset state ----
    check("rst_armed",    armed,       0);
    check("rst_hit",      hit,         0);
    check("rst_miss",     miss,        0);
    check("rst_wrong",    wrong,       0);
    check("rst_reaction", reaction_ms, 0);
    check("rst_score",    score,       0);
    reset = 1'b0;
    tick();

    // ---- basic hit: 420 cycles after arming -> decided at cycle 422 -> 42 ms ----
    arm(5'd5, 12'd100);
    check("basic_armed", armed, 1);
    repeat (420) tick();
    sw[5] = ~sw[5];
    tick();
    check("basic_hit_e1", hit, 0);
    tick();
    check("basic_hit_e2", hit, 0);
    tick();
    check("basic_hit_e3",   hit,         1);
    check("basic_reaction", reaction_ms, 42);
    check("basic_score",    score,       1);
    check("basic_disarm",   armed,       0);
    tick();
    check("basic_single",   hit,         0);

    // ---- timeout: win 20 -> miss on the 201st edge after arming ----
    arm(5'd3, 12'd20);
    first_miss = 0;
    miss_count = 0;
    for (int i = 1; i <= 250; i++) begin
      tick();
      if (miss === 1'b1) begin
        miss_count++;
        if (first_miss == 0) first_miss = i;
      end
    end
    check("to_edge",     first_miss,  201);
    check("to_count",    miss_count,  1);
    check("to_score",    score,       1);
    check("to_reaction", reaction_ms, 42);
    check("to_armed",    armed,       0);

    // ---- wrong switch and floor at zero ----
    arm(5'd7, 12'd100);
    whack(18'(1) << 2);
    check("wr1_wrong", wrong, 1);
    check("wr1_score", score, 0);
    whack(18'(1) << 2);
    check("wr2_wrong", wrong, 1);
    check("wr2_floor", score, 0);
    check("wr2_armed", armed, 1);
    whack(18'(1) << 7);
    check("wr3_hit",   hit,   1);
    check("wr3_score", score, 1);
    arm(5'd7, 12'd100);
    whack(18'(1) << 7);
    check("wr4_score", score, 2);
    arm(5'd7, 12'd100);
    whack(18'(1) << 9);
    check("wr5_wrong", wrong, 1);
    check("wr5_score", score, 1);
    check("wr5_armed", armed, 1);
    whack(18'(1) << 7);
    check("wr6_hit",   hit,   1);
    check("wr6_score", score, 2);

    // ---- correct and wrong switch in the same cycle ----
    arm(5'd4, 12'd100);
    whack((18'(1) << 4) | (18'(1) << 11));
    check("sim_hit",   hit,   1);
    check("sim_wrong", wrong, 0);
    check("sim_score", score, 3);
    tick();
    check("sim_after", wrong, 0);

    // ---- hit on the timeout cycle (win 1: decided in the cycle after edge a+10) ----
    arm(5'd2, 12'd1);
    repeat (8) tick();
    sw[2] = ~sw[2];
    tick();
    tick();
    tick();
    check("tie_hit",      hit,         1);
    check("tie_miss",     miss,        0);
    check("tie_reaction", reaction_ms, 1);
    check("tie_score",    score,       4);
    tick();
    check("tie_nomiss",   miss,        0);

    // ---- mole replaced while armed ----
    arm(5'd1, 12'd100);
    repeat (3) tick();
    arm(5'd6, 12'd100);
    check("rep_miss",  miss,  1);
    check("rep_armed", armed, 1);
    whack(18'(1) << 1);
    check("rep_wrong", wrong, 1);
    check("rep_sc1",   score, 3);
    whack(18'(1) << 6);
    check("rep_hit",      hit,         1);
    check("rep_sc2",      score,       4);
    check("rep_reaction", reaction_ms, 0);

    // ---- reset in the middle of a window ----
    arm(5'd3, 12'd100);
    repeat (5) tick();
    reset = 1'b1;
    sw[5] = ~sw[5];
    tick();
    check("mrst_armed", armed,       0);
    check("mrst_pulse", {hit, miss, wrong}, 0);
    check("mrst_score", score,       0);
    check("mrst_react", reaction_ms, 0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    check("mrst_quiet", {hit, miss, wrong}, 0);

    // ---- window 0: miss on the first armed cycle ----
    arm(5'd3, 12'd0);
    check("w0_armed", armed, 1);
    check("w0_early", miss,  0);
    tick();
    check("w0_miss",  miss,  1);
    check("w0_idle",  armed, 0);

    // ---- out-of-range position: never hit, always times out ----
    arm(5'd20, 12'd2);
    whack(18'(1) << 4);
    check("p20_wrong", wrong, 1);
    check("p20_hit",   hit,   0);
    check("p20_score", score, 0);
    first_miss = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (miss === 1'b1 && first_miss == 0) first_miss = i;
    end
    check("p20_timeout", first_miss, 18);

    // ---- saturation: 9999 back-to-back hits, 3 cycles each ----
    hit_count = 0;
    for (int n = 0; n < 9999; n++) begin
      new_mole      = 1'b1;
      mole_position = 5'd0;
      window_ms     = 12'd100;
      sw[0]         = ~sw[0];
      tick();
      new_mole = 1'b0;
      tick();
      tick();
      if (hit === 1'b1) hit_count++;
    end
    check("sat_hits",  hit_count, 9999);
    check("sat_score", score,     9999);
    arm(5'd0, 12'd100);
    whack(18'(1));
    check("sat_hit",   hit,   1);
    check("sat_hold",  score, 9999);
    arm(5'd0, 12'd100);
    whack(18'(1) << 3);
    check("sat_dec",   score, 9998);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
